// File: rtl/write_row.sv
// Row-write engine: latches one {row_num, data_in} request, commits it into the
// row store one byte lane per clock (LSB first), then pulses output_valid with the row.
module write_row #(
    parameter int ROWS   = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              input_valid,
    input  logic [ADDR_W-1:0] row_num,
    input  logic [DATA_W-1:0] data_in,
    output logic              output_valid,
    output logic [DATA_W-1:0] out,
    output logic              err,
    output logic              busy,
    output logic [7:0]        drop_cnt,
    input  logic [ADDR_W-1:0] rd_row,
    output logic [DATA_W-1:0] rd_data
);

    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                oob_q, oob_d;
    logic                ovld_q, ovld_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic [7:0]          drop_q, drop_d;
    logic [DATA_W-1:0]   mem_q [ROWS];
    logic [DATA_W-1:0]   mem_d [ROWS];
    logic                accept;
    int unsigned         lane_lo;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        data_d  = data_q;
        oob_d   = oob_q;
        ovld_d  = 1'b0;
        err_d   = err_q;
        out_d   = out_q;
        drop_d  = drop_q;
        mem_d   = mem_q;
        accept  = 1'b0;
        lane_lo = 32'(idx_q) * 8;

        case (state_q)
            IDLE: begin
                accept = input_valid;
            end
            WRITE: begin
                if (input_valid && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end
                if (!oob_q) begin
                    mem_d[row_q][lane_lo +: 8] = data_q[lane_lo +: 8];
                end
                if (idx_q == IDX_W'(LANES - 1)) begin
                    // Read back includes the lane committed on this same edge.
                    state_d = ACK;
                    ovld_d  = 1'b1;
                    err_d   = oob_q;
                    out_d   = oob_q ? '0 : mem_d[row_q];
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ACK: begin
                accept  = input_valid;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d = WRITE;
            idx_d   = '0;
            row_d   = row_num;
            data_d  = data_in;
            oob_d   = (32'(row_num) >= 32'(ROWS));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            row_q   <= '0;
            data_q  <= '0;
            oob_q   <= 1'b0;
            ovld_q  <= 1'b0;
            err_q   <= 1'b0;
            out_q   <= '0;
            drop_q  <= '0;
            for (int r = 0; r < ROWS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            data_q  <= data_d;
            oob_q   <= oob_d;
            ovld_q  <= ovld_d;
            err_q   <= err_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (32'(rd_row) < 32'(ROWS)) begin
            rd_data = mem_q[rd_row];
        end
    end

    assign output_valid = ovld_q;
    assign out          = out_q;
    assign err          = err_q;
    assign busy         = (state_q != IDLE);
    assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_write_row.sv
// Scoreboard bench for write_row: expected acks queued at request time,
// popped and compared whenever output_valid is seen.
module tb_write_row;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        input_valid = 1'b0;
    logic [3:0]  row_num = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  rd_row = '0;
    logic        output_valid;
    logic [31:0] out;
    logic        err;
    logic        busy;
    logic [7:0]  drop_cnt;
    logic [31:0] rd_data;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    logic [32:0] exp_q[$];
    logic [32:0] sb_e;

    write_row #(.ROWS(16), .ADDR_W(4), .DATA_W(32)) dut (
        .clk(clk), .rstn(rstn), .input_valid(input_valid), .row_num(row_num),
        .data_in(data_in), .output_valid(output_valid), .out(out), .err(err),
        .busy(busy), .drop_cnt(drop_cnt), .rd_row(rd_row), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (output_valid === 1'b1) begin
            ack_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: ack with err=%b out=%h, required no ack", err, out);
            end else begin
                sb_e = exp_q.pop_front();
                if ({err, out} !== sb_e) begin
                    errors++;
                    $display("FAIL sb_ack: got err=%b out=%h, required err=%b out=%h",
                             err, out, sb_e[32], sb_e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] r, input logic [31:0] d, input bit expect_ack);
        input_valid = 1'b1;
        row_num     = r;
        data_in     = d;
        if (expect_ack) exp_q.push_back({1'b0, d});
        step();
        input_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        checks++;
        if ({output_valid, out, drop_cnt, busy} !== 42'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b out=%h drop=%0d busy=%b, required all 0",
                     output_valid, out, drop_cnt, busy);
        end
        for (int r = 0; r < 16; r++) begin
            rd_row = 4'(r);
            #1;
            checks++;
            if (rd_data !== 32'd0) begin
                errors++;
                $display("FAIL reset_row%0d: got %h, required 0", r, rd_data);
            end
        end
    endtask

    task automatic test_basic();
        req(4'd0, 32'hDEADBEEF, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b, required 1", busy);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (output_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_early_ov E%0d: got %b, required 0", i, output_valid);
            end
        end
        step();
        checks++;
        if ({output_valid, err, out} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL basic_ack_E4: got ov=%b err=%b out=%h, required ov=1 err=0 out=deadbeef",
                     output_valid, err, out);
        end
        step();
        checks++;
        if ({output_valid, busy, out} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL basic_E5: got ov=%b busy=%b out=%h, required ov=0 busy=0 out=deadbeef",
                     output_valid, busy, out);
        end
        rd_row = 4'd0;
        #1;
        checks++;
        if (rd_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_rd: got %h, required deadbeef", rd_data);
        end
    endtask

    task automatic test_progressive();
        logic [31:0] prog_exp [4];
        prog_exp = '{32'h111111DD, 32'h1111CCDD, 32'h11BBCCDD, 32'hAABBCCDD};
        req(4'd3, 32'h11111111, 1'b1);
        repeat (5) step();
        rd_row = 4'd3;
        req(4'd3, 32'hAABBCCDD, 1'b1);
        checks++;
        if (rd_data !== 32'h11111111) begin
            errors++;
            $display("FAIL prog_E0: got %h, required 11111111", rd_data);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (rd_data !== prog_exp[i]) begin
                errors++;
                $display("FAIL prog_E%0d: got %h, required %h", i + 1, rd_data, prog_exp[i]);
            end
        end
        step();
    endtask

    task automatic test_drops();
        int ov_seen;
        ov_seen     = 0;
        input_valid = 1'b1;
        row_num     = 4'd1;
        data_in     = 32'd5;
        exp_q.push_back({1'b0, 32'd5});
        exp_q.push_back({1'b0, 32'd5});
        for (int i = 0; i < 6; i++) begin
            step();
            if (output_valid === 1'b1) ov_seen++;
        end
        input_valid = 1'b0;
        checks++;
        if (ov_seen != 1) begin
            errors++;
            $display("FAIL drops_ack_count: got %0d, required 1", ov_seen);
        end
        checks++;
        if ({drop_cnt, busy} !== {8'd4, 1'b1}) begin
            errors++;
            $display("FAIL drops_cnt: got drop=%0d busy=%b, required drop=4 busy=1", drop_cnt, busy);
        end
        repeat (4) step();
        checks++;
        if ({output_valid, out} !== {1'b1, 32'd5}) begin
            errors++;
            $display("FAIL drops_second_ack: got ov=%b out=%h, required ov=1 out=5", output_valid, out);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  rows [5];
        logic [31:0] fin [4];
        int ack0;
        rows = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3};
        fin  = '{32'd2, 32'd3, 32'd4, 32'd5};
        ack0 = ack_cnt;
        for (int k = 0; k < 5; k++) begin
            req(rows[k], 32'(k + 1), 1'b1);
            repeat (4) step();
        end
        step();
        checks++;
        if ((ack_cnt - ack0) != 5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_acks: got %0d acks busy=%b, required 5 acks busy=0", ack_cnt - ack0, busy);
        end
        for (int r = 0; r < 4; r++) begin
            rd_row = 4'(r);
            #1;
            checks++;
            if (rd_data !== fin[r]) begin
                errors++;
                $display("FAIL b2b_row%0d: got %h, required %h", r, rd_data, fin[r]);
            end
        end
    endtask

    task automatic test_reset_midop();
        int ov_seen;
        ov_seen = 0;
        req(4'd2, 32'hFFFFFFFF, 1'b0);
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        checks++;
        if ({busy, output_valid, drop_cnt} !== 10'd0) begin
            errors++;
            $display("FAIL midop_state: got busy=%b ov=%b drop=%0d, required all 0",
                     busy, output_valid, drop_cnt);
        end
        rd_row = 4'd2;
        #1;
        checks++;
        if (rd_data !== 32'd0) begin
            errors++;
            $display("FAIL midop_row2: got %h, required 0", rd_data);
        end
        rd_row = 4'd0;
        #1;
        checks++;
        if (rd_data !== 32'd0) begin
            errors++;
            $display("FAIL midop_row0: got %h, required 0", rd_data);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (output_valid === 1'b1) ov_seen++;
        end
        checks++;
        if (ov_seen != 0) begin
            errors++;
            $display("FAIL midop_no_ack: got %0d acks, required 0", ov_seen);
        end
    endtask

    task automatic test_reset_vs_valid();
        req(4'd5, 32'h12345678, 1'b0);
        step();
        rstn        = 1'b0;
        input_valid = 1'b1;
        step();
        rstn        = 1'b1;
        input_valid = 1'b0;
        checks++;
        if ({drop_cnt, busy} !== 9'd0) begin
            errors++;
            $display("FAIL rst_vs_valid: got drop=%0d busy=%b, required drop=0 busy=0", drop_cnt, busy);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_vs_valid_idle: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_saturation();
        input_valid = 1'b1;
        row_num     = 4'd4;
        data_in     = 32'd7;
        for (int i = 0; i < 325; i++) begin
            if (i % 5 == 0) exp_q.push_back({1'b0, 32'd7});
            step();
        end
        input_valid = 1'b0;
        checks++;
        if (drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL drop_saturate: got %0d, required 255", drop_cnt);
        end
        step();
        rd_row = 4'd4;
        #1;
        checks++;
        if ({busy, rd_data} !== {1'b0, 32'd7}) begin
            errors++;
            $display("FAIL sat_final: got busy=%b row4=%h, required busy=0 row4=7", busy, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_progressive();
        test_drops();
        test_back_to_back();
        test_reset_midop();
        test_reset_vs_valid();
        test_saturation();
        repeat (2) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending acks, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
